// File: rtl/student_iis_pkg.sv
// student_iis_pkg: shared types and constants for the IIS codec responder.
package student_iis_pkg;
  typedef enum logic [1:0] {ALIGN, DELAY, DATA, PAD} rx_state_e;
  localparam int IIS_DELAY_BITS = 1;
  localparam int IIS_SYNC_STAGES = 2;
endpackage

// File: rtl/student_iis_sync_edge.sv
// student_iis_sync_edge: synchroniser with registered rise/fall strobes (pin edge -> strobe in 3 clk).
module student_iis_sync_edge
  import student_iis_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic [IIS_SYNC_STAGES-1:0] sync_q;
  logic prev_q, rise_q, fall_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[IIS_SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[IIS_SYNC_STAGES-1];
      rise_q <= sync_q[IIS_SYNC_STAGES-1] && !prev_q;
      fall_q <= !sync_q[IIS_SYNC_STAGES-1] && prev_q;
    end
  end
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/student_iis_codec_responder.sv
// student_iis_codec_responder: IIS slave that deserialises DAC data and serialises held tx PCM.
module student_iis_codec_responder
  import student_iis_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_BITS = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  bclk_i,
  input  logic                  lrclk_i,
  input  logic                  sdata_i,
  output logic                  sdata_o,
  output logic [DATA_WIDTH-1:0] rx_left_o,
  output logic [DATA_WIDTH-1:0] rx_right_o,
  output logic                  rx_valid_o,
  output logic                  rx_frame_err_o,
  input  logic [DATA_WIDTH-1:0] tx_left_i,
  input  logic [DATA_WIDTH-1:0] tx_right_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic                  tx_underrun_o
);
  localparam int CW = $clog2(SLOT_BITS);
  logic bclk_rise, bclk_fall, lr_rise, lr_fall, lr_edge;
  logic [IIS_SYNC_STAGES-1:0] sd_q;
  rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ch_q, ch_d, lok_q, lok_d, valid_q, valid_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d, cap_q, cap_d, rxl_q, rxl_d, rxr_q, rxr_d, word;
  logic full_q, full_d, und_q, und_d;
  logic [DATA_WIDTH-1:0] hl_q, hl_d, hr_q, hr_d, al_q, al_d, ar_q, ar_d;
  logic [DATA_WIDTH:0] tsh_q, tsh_d;

  student_iis_sync_edge u_bclk (.clk_i(clk_i), .rst_i(rst_i), .d_i(bclk_i), .rise_o(bclk_rise), .fall_o(bclk_fall));
  student_iis_sync_edge u_lrclk (.clk_i(clk_i), .rst_i(rst_i), .d_i(lrclk_i), .rise_o(lr_rise), .fall_o(lr_fall));

  assign lr_edge = lr_rise || lr_fall;
  assign word = {sh_q[DATA_WIDTH-2:0], sd_q[IIS_SYNC_STAGES-1]};

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ch_d = ch_q;
    lok_d = lok_q;
    sh_d = sh_q;
    cap_d = cap_q;
    rxl_d = rxl_q;
    rxr_d = rxr_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    full_d = full_q;
    hl_d = hl_q;
    hr_d = hr_q;
    al_d = al_q;
    ar_d = ar_q;
    und_d = 1'b0;
    tsh_d = bclk_fall ? tsh_q << 1 : tsh_q;
    if (lr_edge && (lr_fall || state_q != ALIGN)) begin
      state_d = DELAY;
      cnt_d = '0;
      ch_d = lr_rise;
      err_d = (state_q == DELAY) || (state_q == DATA);
      lok_d = lok_q && lr_rise;
    end else if (bclk_rise && state_q == DELAY) begin
      state_d = (cnt_q == CW'(IIS_DELAY_BITS - 1)) ? DATA : DELAY;
      cnt_d = (cnt_q == CW'(IIS_DELAY_BITS - 1)) ? '0 : cnt_q + 1'b1;
    end else if (bclk_rise && state_q == DATA) begin
      sh_d = word;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(DATA_WIDTH - 1)) begin
        state_d = PAD;
        if (!ch_q) begin
          cap_d = word;
          lok_d = 1'b1;
        end else if (lok_q) begin
          rxl_d = cap_q;
          rxr_d = word;
          valid_d = 1'b1;
        end
      end
    end
    // a frame whose left slot was lost never publishes, so lok gates the right-word load
    if (lr_fall) begin
      full_d = 1'b0;
      al_d = full_q ? hl_q : al_q;
      ar_d = full_q ? hr_q : ar_q;
      und_d = !full_q;
    end
    if (tx_valid_i && !full_q) begin
      full_d = 1'b1;
      hl_d = tx_left_i;
      hr_d = tx_right_i;
    end
    if (lr_edge) tsh_d = {1'b0, lr_rise ? ar_q : al_d};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sd_q <= '0;
      state_q <= ALIGN;
      cnt_q <= '0;
      ch_q <= 1'b0;
      lok_q <= 1'b0;
      sh_q <= '0;
      cap_q <= '0;
      rxl_q <= '0;
      rxr_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      full_q <= 1'b0;
      hl_q <= '0;
      hr_q <= '0;
      al_q <= '0;
      ar_q <= '0;
      und_q <= 1'b0;
      tsh_q <= '0;
    end else begin
      sd_q <= {sd_q[IIS_SYNC_STAGES-2:0], sdata_i};
      state_q <= state_d;
      cnt_q <= cnt_d;
      ch_q <= ch_d;
      lok_q <= lok_d;
      sh_q <= sh_d;
      cap_q <= cap_d;
      rxl_q <= rxl_d;
      rxr_q <= rxr_d;
      valid_q <= valid_d;
      err_q <= err_d;
      full_q <= full_d;
      hl_q <= hl_d;
      hr_q <= hr_d;
      al_q <= al_d;
      ar_q <= ar_d;
      und_q <= und_d;
      tsh_q <= tsh_d;
    end
  end

  assign sdata_o = (state_q != ALIGN) && tsh_q[DATA_WIDTH];
  assign rx_left_o = rxl_q;
  assign rx_right_o = rxr_q;
  assign rx_valid_o = valid_q;
  assign rx_frame_err_o = err_q;
  assign tx_ready_o = !full_q;
  assign tx_underrun_o = und_q;
endmodule
